// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit-position counter width; never narrower than one bit so WIDTH=1 still has a counter.
   function automatic int cnt_width(input int w);
      int r;
      r = $clog2(w);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fa_cell.sv
// Single full-adder cell, time-shared by the serial adder sequencer.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell per clock, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub port (a-b in two's complement).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CLK100MHZ,
   input  logic             CPU_RESETN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // operands are taken only in IDLE, and the result stays stable while out_valid waits on out_ready.

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s;
   logic             c;
   logic             sub_q;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_q = sub;
`else
   assign sub_q = 1'b0;
`endif

   fa_cell u_fa (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (carry),
      .s   (s),
      .co  (c)
   );

   // The new sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts.
   always_comb begin
      sum_nxt = sum_sh >> 1;
      sum_nxt[WIDTH-1] = s;
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= sub_q ? ~b : b;
                  carry    <= sub_q;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= sum_nxt;
               carry  <= c;
               cnt    <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  out_valid <= 1'b1;
                  sum       <= sum_nxt;
                  cout      <= c;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
